// File: rtl/serial_prefix_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract unit.
package serial_prefix_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    // Digit counter needs at least one bit even for a single-digit operand.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/serial_prefix_addsub_prefix_slice4.sv
// 4-bit Kogge-Stone adder slice; cin is merged into bit-0 generate so the
// prefix tree yields every carry, including carry-out, directly.
module prefix_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g0;
    logic [3:0] g1;
    logic [3:0] p1;
    logic [3:0] g2;

    always_comb begin
        p     = a ^ b;
        g0    = a & b;
        g0[0] = (a[0] & b[0]) | (p[0] & cin);

        // distance-1 operators
        g1[0] = g0[0];
        p1[0] = p[0];
        for (int i = 1; i < 4; i++) begin
            g1[i] = g0[i] | (p[i] & g0[i-1]);
            p1[i] = p[i] & p[i-1];
        end

        // distance-2 operators
        g2[1:0] = g1[1:0];
        for (int i = 2; i < 4; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
        end

        s[0] = p[0] ^ cin;
        for (int i = 1; i < 4; i++) begin
            s[i] = p[i] ^ g2[i-1];
        end
        cout = g2[3];
    end

endmodule

// File: rtl/serial_prefix_addsub.sv
// Digit-serial add/subtract: one 4-bit prefix slice reused DIGITS times,
// LSB digit first, with the carry held in a register between digits.
//
//  state | meaning
//  IDLE  | ready for an operand set
//  RUN   | one digit per cycle through the slice
//  DONE  | result valid, held until the consumer accepts it
module serial_prefix_addsub
    import serial_prefix_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CW     = cnt_width(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q;

    logic [DIGIT_W-1:0] dig_a;
    logic [DIGIT_W-1:0] dig_b;
    logic [DIGIT_W-1:0] dig_s;
    logic               dig_cout;

    assign dig_a = a_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];
    assign dig_b = b_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];

    prefix_slice4 u_slice (
        .a   (dig_a),
        .b   (dig_b),
        .cin (carry_q),
        .s   (dig_s),
        .cout(dig_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(cnt_q)*DIGIT_W +: DIGIT_W] = dig_s;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // the last digit's s[3] is the result MSB
                    cout_d  = dig_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (dig_s[DIGIT_W-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_prefix_addsub.sv
// Directed bench for serial_prefix_addsub at WIDTH=16.
module tb_serial_prefix_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_prefix_addsub #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        sub      = sv;
        cyc      = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 32'd4);
    endtask

    task automatic check_res(input string tag, input logic [15:0] r, input logic c, input logic o);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, r});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, o});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rel_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rel_inrdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_inrdy", {31'd0, in_ready}, 32'd1);

        accept(16'h1234, 16'h0FFF, 1'b0);
        wait_done("add1");
        check_res("add1", 16'h2233, 1'b0, 1'b0);
        release_out("add1");

        accept(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ripple");
        check_res("ripple", 16'h0000, 1'b1, 1'b0);
        release_out("ripple");

        accept(16'h0005, 16'h0007, 1'b1);
        wait_done("sub_borrow");
        check_res("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        release_out("sub_borrow");

        accept(16'h0007, 16'h0005, 1'b1);
        wait_done("sub_pos");
        check_res("sub_pos", 16'h0002, 1'b1, 1'b0);
        release_out("sub_pos");

        accept(16'h7FFF, 16'h0001, 1'b0);
        wait_done("add_ovf");
        check_res("add_ovf", 16'h8000, 1'b0, 1'b1);
        release_out("add_ovf");

        accept(16'h8000, 16'h0001, 1'b1);
        wait_done("sub_ovf");
        check_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
        release_out("sub_ovf");

        // Backpressure with the next operand set already offered.
        accept(16'h4321, 16'h1111, 1'b0);
        wait_done("bp");
        in_valid = 1'b1;
        a        = 16'h0100;
        b        = 16'h0001;
        sub      = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {16'd0, result}, 32'h5432);
            chk("bp_inrdy", {31'd0, in_ready}, 32'd0);
        end
        check_res("bp", 16'h5432, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_inrdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b");
        check_res("b2b", 16'h00FF, 1'b1, 1'b0);
        release_out("b2b");

        // Reset after two digits have been processed.
        accept(16'hAAAA, 16'h1111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_inrdy", {31'd0, in_ready}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_inrdy_after", {31'd0, in_ready}, 32'd1);

        accept(16'h00FF, 16'h0001, 1'b0);
        wait_done("after_abort");
        check_res("after_abort", 16'h0100, 1'b0, 1'b0);
        release_out("after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
